// File: rtl/m_rst_seq_pkg.sv
// Shared FSM encoding and default parameters for the reset sequencer.
package m_rst_pkg;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_RELEASE,
        ST_RUN,
        ST_SWHOLD
    } state_e;

    localparam int DEF_N_OUT       = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_GAP_CYC     = 16;
    localparam int DEF_HOLD_CYC    = 8;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/m_rst_seq_if.sv
// Software-request handshake and sequenced reset outputs of m_rst_seq.
interface m_rst_seq_if #(
    parameter int N_OUT = 4
) ();
    logic             sw_req;
    logic [N_OUT-1:0] rn_o;
    logic             done;
    logic             sw_busy;
    logic             sw_ack;

    modport master (output sw_req, input rn_o, done, sw_busy, sw_ack);
    modport slave  (input sw_req, output rn_o, done, sw_busy, sw_ack);
endinterface

// File: rtl/m_rst_sync.sv
// Async-assert / sync-deassert reset synchronizer fed a constant 1.
module m_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic CK,
    input  logic R,
    output logic pre_o,
    output logic sync_o
);
    logic [STAGES-1:0] chain_q, chain_d;

    always_comb chain_d = {chain_q[STAGES-2:0], 1'b1};

    always_ff @(posedge CK or posedge R) begin
        if (R) chain_q <= '0;
        else   chain_q <= chain_d;
    end

    // pre_o rises one edge ahead of sync_o so the consumer can act on the same edge sync_o rises
    assign pre_o  = chain_q[STAGES-2];
    assign sync_o = chain_q[STAGES-1];
endmodule

// File: rtl/m_rst_seq.sv
// Staged reset release sequencer with software-triggered re-sequencing.
module m_rst_seq
    import m_rst_pkg::*;
#(
    parameter int N_OUT       = DEF_N_OUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC
) (
    input  logic        CK,
    input  logic        R,
    m_rst_seq_if.slave  bus
);
    localparam int CW = $clog2(max_i(GAP_CYC, HOLD_CYC) + 1);
    localparam int IW = $clog2(N_OUT + 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [IW-1:0] IDX_LST = IW'(N_OUT - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_OUT-1:0] rn_q, rn_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             sync_pre, sync_rdy;

    m_rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .CK     (CK),
        .R      (R),
        .pre_o  (sync_pre),
        .sync_o (sync_rdy)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rn_d    = rn_q;
        done_d  = done_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        unique case (state_q)
            ST_SYNC: begin
                if (sync_pre) begin
                    state_d = ST_RELEASE;
                    cnt_d   = GAP_LD;
                    idx_d   = '0;
                end
            end
            ST_RELEASE: begin
                // sync_rdy is an interlock: no output may release before the synchronizer has
                if (cnt_q == CNT_ONE && sync_rdy) begin
                    for (int i = 0; i < N_OUT; i++)
                        if (idx_q == IW'(i)) rn_d[i] = 1'b1;
                    cnt_d = GAP_LD;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        ack_d   = busy_q;
                        busy_d  = 1'b0;
                    end
                end else if (cnt_q != CNT_ONE) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.sw_req) begin
                    state_d = ST_SWHOLD;
                    rn_d    = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = HOLD_LD;
                end
            end
            ST_SWHOLD: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RELEASE;
                    cnt_d   = GAP_LD;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            rn_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rn_q    <= rn_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.rn_o    = rn_q;
    assign bus.done    = done_q;
    assign bus.sw_busy = busy_q;
    assign bus.sw_ack  = ack_q;
endmodule
